// File: rtl/wine_header_collector_pkg.sv
// Shared definitions for the Wine header collector: default widths and the
// collector's state encoding.
package wine_pkg;

    localparam int DEF_BEAT_W = 64;
    localparam int DEF_HDR_W  = 512;
    localparam int DEF_BEATS  = DEF_HDR_W / DEF_BEAT_W;

    typedef enum logic [1:0] {
        COLLECT,
        DRAIN,
        WAIT_OUT
    } state_e;

endpackage

// File: rtl/wine_header_collector_if.sv
// Ingress beat stream plus the captured-header output of the collector.
// The slave modport is the collector itself; master is its environment.
interface wine_header_collector_if
    import wine_pkg::*;
#(
    parameter int BEAT_W = DEF_BEAT_W,
    parameter int HDR_W  = DEF_HDR_W
);
    localparam int BEATS = HDR_W / BEAT_W;
    localparam int CNT_W = $clog2(BEATS) + 1;

    logic [BEAT_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic              s_tlast;
    logic [HDR_W-1:0]  o_packet;
    logic              o_valid;
    logic              i_ready;
    logic [CNT_W-1:0]  o_beats;
    logic              o_truncated;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, i_ready,
        output s_tready, o_packet, o_valid, o_beats, o_truncated
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, i_ready,
        input  s_tready, o_packet, o_valid, o_beats, o_truncated
    );

endinterface

// File: rtl/wine_header_collector.sv
// Captures the first HDR_W bits of each packet (first beat most significant),
// presents them as one word and drains the remainder of the packet.
module wine_header_collector
    import wine_pkg::*;
#(
    parameter int BEAT_W = DEF_BEAT_W,
    parameter int HDR_W  = DEF_HDR_W
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    wine_header_collector_if.slave bus
);

    localparam int BEATS = HDR_W / BEAT_W;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [HDR_W-1:0]  packet_q, packet_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  beats_q, beats_d;
    logic              trunc_q, trunc_d;
    logic              hs;
    logic              beatFire;

    assign hs       = valid_q && bus.i_ready;
    assign beatFire = bus.s_tvalid && (state_q != WAIT_OUT);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        packet_d = packet_q;
        valid_d  = valid_q;
        beats_d  = beats_q;
        trunc_d  = trunc_q;

        case (state_q)
            COLLECT: begin
                if (beatFire) begin
                    packet_d[HDR_W-1-int'(idx_q)*BEAT_W -: BEAT_W] = bus.s_tdata;
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + 1'b1;
                    end
                    if (bus.s_tlast) begin
                        valid_d = 1'b1;
                        beats_d = CNT_W'(idx_q) + CNT_W'(1);
                        trunc_d = 1'b0;
                        state_d = WAIT_OUT;
                    end else if (idx_q == LAST_IDX) begin
                        valid_d = 1'b1;
                        beats_d = CNT_W'(BEATS);
                        trunc_d = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // valid_q low here means the header already left in an earlier cycle.
                if (beatFire && bus.s_tlast) begin
                    state_d = (hs || !valid_q) ? COLLECT : WAIT_OUT;
                end
            end
            WAIT_OUT: begin
                if (hs) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase

        // Clearing on handshake also provides the zero padding for short packets.
        if (hs) begin
            valid_d  = 1'b0;
            packet_d = '0;
            beats_d  = '0;
            trunc_d  = 1'b0;
            idx_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COLLECT;
            idx_q    <= '0;
            packet_q <= '0;
            valid_q  <= 1'b0;
            beats_q  <= '0;
            trunc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            packet_q <= packet_d;
            valid_q  <= valid_d;
            beats_q  <= beats_d;
            trunc_q  <= trunc_d;
        end
    end

    assign bus.s_tready    = rst_n && (state_q != WAIT_OUT);
    assign bus.o_packet    = packet_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_beats     = beats_q;
    assign bus.o_truncated = trunc_q;

endmodule

// File: tb/tb_wine_header_collector.sv
// Scoreboard bench for wine_header_collector: expected headers are queued as
// packets are sent and popped as the collector hands them out.
module tb_wine_header_collector;

    localparam int BEAT_W = 64;
    localparam int HDR_W  = 512;
    localparam int BEATS  = 8;

    typedef struct {
        logic [HDR_W-1:0] pkt;
        logic [3:0]       beats;
        logic             trunc;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    wine_header_collector_if #(.BEAT_W(BEAT_W), .HDR_W(HDR_W)) bus ();

    wine_header_collector #(.BEAT_W(BEAT_W), .HDR_W(HDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BEAT_W-1:0] rand_beat();
        return {$urandom(), $urandom()};
    endfunction

    // Model: shift beats in from the right, then left-align a short packet.
    task automatic push_expect(input logic [BEAT_W-1:0] d[$]);
        exp_t e;
        int   n;
        e.pkt = '0;
        n = (d.size() > BEATS) ? BEATS : d.size();
        for (int k = 0; k < n; k++) e.pkt = {e.pkt[HDR_W-BEAT_W-1:0], d[k]};
        e.pkt   = e.pkt << ((BEATS - n) * BEAT_W);
        e.beats = 4'(n);
        e.trunc = (d.size() > BEATS);
        sb.push_back(e);
    endtask

    task automatic drive_beat(input logic [BEAT_W-1:0] d, input logic last,
                              output bit ok, output bit stalled);
        int n = 0;
        bus.s_tdata  = d;
        bus.s_tvalid = 1'b1;
        bus.s_tlast  = last;
        stalled = !bus.s_tready;
        while (!bus.s_tready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        ok = bus.s_tready;
        @(posedge clk); #1;
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
    endtask

    task automatic send_packet(input logic [BEAT_W-1:0] d[$], output bit ok, output int stalls);
        bit okb, st;
        ok = 1'b1;
        stalls = 0;
        push_expect(d);
        for (int i = 0; i < d.size(); i++) begin
            drive_beat(d[i], i == d.size() - 1, okb, st);
            ok &= okb;
            stalls += int'(st);
        end
    endtask

    task automatic get_output(input int hold, output logic [HDR_W-1:0] pkt, output logic [3:0] nb,
                              output logic tr, output bit ok, output bit stable);
        int n = 0;
        bus.i_ready = 1'b0;
        while (!bus.o_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        ok = bus.o_valid;
        pkt = bus.o_packet;
        nb  = bus.o_beats;
        tr  = bus.o_truncated;
        stable = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (bus.o_packet !== pkt || bus.o_beats !== nb || bus.o_truncated !== tr || !bus.o_valid)
                stable = 1'b0;
        end
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.s_tdata = '0; bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0; bus.i_ready = 1'b0;
        #1;
        checks++;
        if (bus.s_tready !== 1'b0) $display("[TB] FAIL reset_tready_low: got %b expected 0", bus.s_tready);
        else passes++;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_beats !== 4'd0 || bus.o_truncated !== 1'b0)
            $display("[TB] FAIL reset_outputs: valid=%b beats=%0d trunc=%b expected 0 0 0",
                     bus.o_valid, bus.o_beats, bus.o_truncated);
        else passes++;
        checks++;
        if (bus.o_packet !== '0) $display("[TB] FAIL reset_packet: got %h expected 0", bus.o_packet);
        else passes++;
        checks++;
        if (bus.s_tready !== 1'b1) $display("[TB] FAIL reset_tready: got %b expected 1", bus.s_tready);
        else passes++;
    endtask

    task automatic test_truncated();
        logic [BEAT_W-1:0] d[$];
        logic [HDR_W-1:0]  pkt;
        logic [3:0]        nb;
        logic              tr;
        bit okS, okG, stable;
        int stalls;
        exp_t e;
        for (int i = 0; i < 10; i++) d.push_back(rand_beat());
        fork
            send_packet(d, okS, stalls);
            get_output(4, pkt, nb, tr, okG, stable);
        join
        e = sb.pop_front();
        checks++;
        if (!okS || !okG || stalls != 0)
            $display("[TB] FAIL trunc_flow: send_ok=%b out_ok=%b stalls=%0d expected 1 1 0", okS, okG, stalls);
        else passes++;
        checks++;
        if (pkt !== e.pkt) $display("[TB] FAIL trunc_packet: got %h expected %h", pkt, e.pkt);
        else passes++;
        checks++;
        if (nb !== 4'd8 || tr !== 1'b1) $display("[TB] FAIL trunc_meta: beats=%0d trunc=%b expected 8 1", nb, tr);
        else passes++;
    endtask

    task automatic test_short();
        logic [BEAT_W-1:0] d[$];
        logic [HDR_W-1:0]  pkt;
        logic [3:0]        nb;
        logic              tr;
        bit okS, okG, stable;
        int stalls;
        exp_t e;
        for (int i = 0; i < 3; i++) d.push_back(rand_beat());
        fork
            send_packet(d, okS, stalls);
            get_output(0, pkt, nb, tr, okG, stable);
        join
        e = sb.pop_front();
        checks++;
        if (!okG || pkt[511:320] !== {d[0], d[1], d[2]})
            $display("[TB] FAIL short_head: ok=%b got %h expected %h", okG, pkt[511:320], {d[0], d[1], d[2]});
        else passes++;
        checks++;
        if (pkt[319:0] !== 320'h0) $display("[TB] FAIL short_pad: got %h expected 0", pkt[319:0]);
        else passes++;
        checks++;
        if (nb !== e.beats || tr !== e.trunc)
            $display("[TB] FAIL short_meta: beats=%0d trunc=%b expected %0d %b", nb, tr, e.beats, e.trunc);
        else passes++;
    endtask

    task automatic test_exact8();
        logic [BEAT_W-1:0] d[$];
        bit ok, st, allOk, waitLow;
        logic [HDR_W-1:0] pkt;
        logic [3:0] nb;
        exp_t e;
        for (int i = 0; i < BEATS; i++) d.push_back(rand_beat());
        push_expect(d);
        allOk = 1'b1;
        for (int i = 0; i < BEATS; i++) begin
            drive_beat(d[i], i == BEATS - 1, ok, st);
            allOk &= ok;
        end
        checks++;
        if (!allOk || bus.o_valid !== 1'b1 || bus.o_truncated !== 1'b0)
            $display("[TB] FAIL exact8_valid: ok=%b valid=%b trunc=%b expected 1 1 0", allOk, bus.o_valid, bus.o_truncated);
        else passes++;
        waitLow = (bus.s_tready === 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.s_tready !== 1'b0) waitLow = 1'b0;
        end
        checks++;
        if (!waitLow) $display("[TB] FAIL exact8_wait_tready: got tready high expected 0 in WAIT_OUT");
        else passes++;
        pkt = bus.o_packet;
        nb  = bus.o_beats;
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        checks++;
        if (bus.s_tready !== 1'b1 || bus.o_valid !== 1'b0)
            $display("[TB] FAIL exact8_after_hs: tready=%b valid=%b expected 1 0", bus.s_tready, bus.o_valid);
        else passes++;
        e = sb.pop_front();
        checks++;
        if (pkt !== e.pkt || nb !== 4'd8)
            $display("[TB] FAIL exact8_packet: got %h/%0d expected %h/8", pkt, nb, e.pkt);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [BEAT_W-1:0] a[$], b[$];
        logic [HDR_W-1:0]  pa, pb;
        logic [3:0]        na, nbb;
        logic              ta, tb;
        bit okA, okB, okGA, okGB, stA, stB;
        int sa, sbn;
        exp_t ea, eb;
        for (int i = 0; i < 4; i++) a.push_back(rand_beat());
        for (int i = 0; i < 2; i++) b.push_back(rand_beat());
        fork
            begin
                send_packet(a, okA, sa);
                send_packet(b, okB, sbn);
            end
            begin
                get_output(5, pa, na, ta, okGA, stA);
                get_output(0, pb, nbb, tb, okGB, stB);
            end
        join
        ea = sb.pop_front();
        eb = sb.pop_front();
        checks++;
        if (!stA || !okGA) $display("[TB] FAIL b2b_stable: stable=%b ok=%b expected 1 1", stA, okGA);
        else passes++;
        checks++;
        if (pa !== ea.pkt || na !== ea.beats)
            $display("[TB] FAIL b2b_first: got %h/%0d expected %h/%0d", pa, na, ea.pkt, ea.beats);
        else passes++;
        checks++;
        if (!okB || !okGB || pb !== {b[0], b[1], 384'h0})
            $display("[TB] FAIL b2b_second: got %h expected %h", pb, {b[0], b[1], 384'h0});
        else passes++;
        checks++;
        if (nbb !== eb.beats || tb !== eb.trunc)
            $display("[TB] FAIL b2b_second_meta: beats=%0d trunc=%b expected %0d %b", nbb, tb, eb.beats, eb.trunc);
        else passes++;
    endtask

    task automatic test_drain_handshake();
        logic [BEAT_W-1:0] d[$], g[$];
        logic [HDR_W-1:0]  pkt, pg;
        logic [3:0]        nb, ng;
        logic              tr, tg;
        bit ok, st, okS, okG, stable;
        int stalls;
        exp_t e;
        for (int i = 0; i < 10; i++) d.push_back(rand_beat());
        push_expect(d);
        for (int i = 0; i < BEATS; i++) drive_beat(d[i], 1'b0, ok, st);
        checks++;
        if (bus.o_valid !== 1'b1) $display("[TB] FAIL drain_valid: got %b expected 1", bus.o_valid);
        else passes++;
        bus.s_tdata = d[8]; bus.s_tvalid = 1'b1; bus.s_tlast = 1'b0;
        @(posedge clk); #1;
        pkt = bus.o_packet; nb = bus.o_beats; tr = bus.o_truncated;
        bus.s_tdata = d[9]; bus.s_tlast = 1'b1; bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0; bus.i_ready = 1'b0;
        checks++;
        if (bus.s_tready !== 1'b1 || bus.o_valid !== 1'b0)
            $display("[TB] FAIL drain_hs_next: tready=%b valid=%b expected 1 0", bus.s_tready, bus.o_valid);
        else passes++;
        e = sb.pop_front();
        checks++;
        if (pkt !== e.pkt || nb !== 4'd8 || tr !== 1'b1)
            $display("[TB] FAIL drain_packet: got %h/%0d/%b expected %h/8/1", pkt, nb, tr, e.pkt);
        else passes++;
        g.push_back(rand_beat());
        fork
            send_packet(g, okS, stalls);
            get_output(0, pg, ng, tg, okG, stable);
        join
        e = sb.pop_front();
        checks++;
        if (!okS || !okG || pg !== e.pkt || ng !== 4'd1 || tg !== 1'b0)
            $display("[TB] FAIL drain_follow: got %h/%0d/%b expected %h/1/0", pg, ng, tg, e.pkt);
        else passes++;
    endtask

    task automatic test_reset_midpacket();
        logic [BEAT_W-1:0] f[$];
        logic [HDR_W-1:0]  pkt;
        logic [3:0]        nb;
        logic              tr;
        bit ok, st, okS, okG, stable;
        int stalls;
        for (int i = 0; i < 4; i++) drive_beat(rand_beat(), 1'b0, ok, st);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_packet !== '0 || bus.o_valid !== 1'b0 || bus.o_beats !== 4'd0 ||
            bus.o_truncated !== 1'b0 || bus.s_tready !== 1'b0)
            $display("[TB] FAIL midreset_clear: packet_nonzero=%b valid=%b beats=%0d tready=%b expected 0 0 0 0",
                     |bus.o_packet, bus.o_valid, bus.o_beats, bus.s_tready);
        else passes++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        f.push_back(rand_beat());
        fork
            send_packet(f, okS, stalls);
            get_output(0, pkt, nb, tr, okG, stable);
        join
        void'(sb.pop_front());
        checks++;
        if (!okG || pkt !== {f[0], 448'h0} || nb !== 4'd1 || tr !== 1'b0)
            $display("[TB] FAIL midreset_next: got %h/%0d/%b expected %h/1/0", pkt, nb, tr, {f[0], 448'h0});
        else passes++;
    endtask

    initial begin
        test_reset();
        test_truncated();
        test_short();
        test_exact8();
        test_back_to_back();
        test_drain_handshake();
        test_reset_midpacket();
        checks++;
        if (sb.size() != 0) $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
